codeword_timer: RTL and testbench

Run-time programmable bit-slot scheduler for the linear block code datapath. It divides `clk` by a configurable ratio to produce single-cycle bit strobes, and groups them into codeword frames of `CW_LEN` bits. The encoder and decoder stages use these strobes as clock enables instead of a derived clock. Start, graceful stop and ratio changes are sequenced so a frame is never truncated and the ratio never changes mid-frame.

---
 rtl/codeword_timer_pkg.sv | 19 +
 rtl/codeword_timer_slot_counter.sv | 48 ++++
 rtl/codeword_timer.sv | 167 ++++++++++++++++
 tb/tb_codeword_timer.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/codeword_timer_pkg.sv
// -----------------------------------------------------------------------------
// codeword_timer_pkg
// Shared types and constants for the codeword bit-slot scheduler.
//   cw_state_e      : scheduler state (IDLE, RUN, DRAIN)
//   DIV_MIN         : smallest divide ratio that can be active
//   CW_LEN_DEFAULT  : default number of bit slots per codeword frame
// -----------------------------------------------------------------------------
package codeword_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } cw_state_e;

    localparam int unsigned DIV_MIN        = 2;
    localparam int unsigned CW_LEN_DEFAULT = 7;

endpackage

// File: rtl/codeword_timer_slot_counter.sv
// -----------------------------------------------------------------------------
// slot_counter
// Modulo-div counter used to time one bit slot.
//   clk, rst : clock, asynchronous active-high reset
//   en       : advance the count this cycle
//   clr      : synchronous clear to 0 (overrides en)
//   div      : modulus; count runs 0..div-1
//   cnt      : current count
//   tc       : terminal count (cnt == div-1), decoded from the register
// -----------------------------------------------------------------------------
module slot_counter
    import codeword_timer_pkg::*;
#(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         clr,
    input  logic [W-1:0] div,
    output logic [W-1:0] cnt,
    output logic         tc
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        tc    = (cnt_q == (div - W'(1)));
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = tc ? '0 : (cnt_q + W'(1));
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/codeword_timer.sv
// -----------------------------------------------------------------------------
// codeword_timer
// Run-time programmable bit-slot scheduler. Divides clk by an active ratio to
// give single-cycle bit strobes and groups CW_LEN of them into a codeword frame.
// Frames are never truncated by stop, and ratio changes take effect only at a
// frame boundary (or immediately while idle).
//
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   start, stop : level-sampled framing requests
//   cfg_valid   : new divide ratio offered on cfg_div
//   cfg_ready   : ratio can be accepted this cycle
//   busy        : scheduler not idle
//   bit_tick    : pulse on the last clock of each bit slot
//   bit_idx     : index of the current bit within the frame
//   word_start  : pulse on the first clock of a frame
//   word_end    : pulse on the final bit_tick of a frame
//   div_level   : divided-clock level (only when CODEWORD_TIMER_LEVEL_EN is
//                 defined; port absent otherwise)
// -----------------------------------------------------------------------------
module codeword_timer
    import codeword_timer_pkg::*;
#(
    parameter int unsigned CW_LEN  = CW_LEN_DEFAULT,
    parameter int unsigned DIV_W   = 8,
    parameter int unsigned DIV_RST = 7
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic                      stop,
    input  logic                      cfg_valid,
    input  logic [DIV_W-1:0]          cfg_div,
    output logic                      cfg_ready,
    output logic                      busy,
    output logic                      bit_tick,
    output logic [$clog2(CW_LEN)-1:0] bit_idx,
    output logic                      word_start,
    output logic                      word_end
`ifdef CODEWORD_TIMER_LEVEL_EN
    ,
    output logic                      div_level
`endif
);

    localparam int unsigned        IDX_W     = $clog2(CW_LEN);
    localparam logic [IDX_W-1:0]   IDX_LAST  = IDX_W'(CW_LEN - 1);
    localparam logic [DIV_W-1:0]   DIV_MIN_W = DIV_W'(DIV_MIN);
    localparam logic [DIV_W-1:0]   DIV_RST_W = DIV_W'(DIV_RST);

    cw_state_e          state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic               pend_q, pend_d;
    logic [DIV_W-1:0]   pend_div_q, pend_div_d;
    logic [IDX_W-1:0]   bit_idx_q, bit_idx_d;

    logic [DIV_W-1:0]   cnt;
    logic               cnt_tc;
    logic               cnt_clr;
    logic               cfg_xfer;
    logic [DIV_W-1:0]   cfg_val;

    assign busy    = (state_q != ST_IDLE);
    assign cnt_clr = ~busy;

    slot_counter #(
        .W (DIV_W)
    ) u_slot_counter (
        .clk (clk),
        .rst (rst),
        .en  (busy),
        .clr (cnt_clr),
        .div (div_q),
        .cnt (cnt),
        .tc  (cnt_tc)
    );

    assign bit_tick   = busy & cnt_tc;
    assign word_end   = bit_tick & (bit_idx_q == IDX_LAST);
    assign word_start = busy & (cnt == '0) & (bit_idx_q == '0);
    assign bit_idx    = bit_idx_q;

    assign cfg_ready = ~busy | ~pend_q;
    assign cfg_xfer  = cfg_valid & cfg_ready;
    assign cfg_val   = (cfg_div < DIV_MIN_W) ? DIV_MIN_W : cfg_div;

    // Framing state machine
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (stop) state_d = word_end ? ST_IDLE : ST_DRAIN;
            end
            ST_DRAIN: begin
                // A late start cancels the drain even on the final tick, so
                // framing continues without a gap.
                if (start && !stop) state_d = ST_RUN;
                else if (word_end)  state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        bit_idx_d = bit_idx_q;
        if (!busy) begin
            bit_idx_d = '0;
        end else if (bit_tick) begin
            bit_idx_d = (bit_idx_q == IDX_LAST) ? '0 : (bit_idx_q + IDX_W'(1));
        end
    end

    // Ratio handling. While busy a transfer only lands in the pending slot
    // (cfg_ready guarantees the slot is free), and the slot is promoted at
    // word_end. A pending value left over when the timer falls idle is
    // promoted straight away; a fresh idle transfer overrides it.
    always_comb begin
        div_d      = div_q;
        pend_d     = pend_q;
        pend_div_d = pend_div_q;
        if (!busy) begin
            if (pend_q) begin
                div_d  = pend_div_q;
                pend_d = 1'b0;
            end
            if (cfg_xfer) begin
                div_d = cfg_val;
            end
        end else begin
            if (word_end && pend_q) begin
                div_d  = pend_div_q;
                pend_d = 1'b0;
            end
            if (cfg_xfer) begin
                pend_d     = 1'b1;
                pend_div_d = cfg_val;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            div_q      <= DIV_RST_W;
            pend_q     <= 1'b0;
            pend_div_q <= '0;
            bit_idx_q  <= '0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            pend_q     <= pend_d;
            pend_div_q <= pend_div_d;
            bit_idx_q  <= bit_idx_d;
        end
    end

`ifdef CODEWORD_TIMER_LEVEL_EN
    // High phase is ceil(div/2) cycles; extra bit avoids overflow at max div.
    logic [DIV_W:0] half_div;
    assign half_div  = ({1'b0, div_q} + (DIV_W+1)'(1)) >> 1;
    assign div_level = busy & ({1'b0, cnt} < half_div);
`endif

endmodule

// File: tb/tb_codeword_timer.sv
module tb_codeword_timer;

    localparam int CW = 7;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       stop;
    logic       cfg_valid;
    logic [7:0] cfg_div;
    logic       cfg_ready;
    logic       busy;
    logic       bit_tick;
    logic [2:0] bit_idx;
    logic       word_start;
    logic       word_end;
`ifdef CODEWORD_TIMER_LEVEL_EN
    logic       div_level;
`endif

    codeword_timer #(
        .CW_LEN  (CW),
        .DIV_W   (8),
        .DIV_RST (7)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .stop       (stop),
        .cfg_valid  (cfg_valid),
        .cfg_div    (cfg_div),
        .cfg_ready  (cfg_ready),
        .busy       (busy),
        .bit_tick   (bit_tick),
        .bit_idx    (bit_idx),
        .word_start (word_start),
        .word_end   (word_end)
`ifdef CODEWORD_TIMER_LEVEL_EN
        ,
        .div_level  (div_level)
`endif
    );

    always #5 clk = ~clk;

    int cyc  = 0;
    int base = 0;
    int n_cmp = 0;
    int n_bad = 0;
    logic mon_en = 1'b0;

    // Expected events, encoded kind*100000 + cycle*10 + bit_idx
    // kind: 1 word_start, 2 bit_tick, 3 word_end
    int exp_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int cur();
        return cyc - base;
    endfunction

    task automatic check_eq(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cur());
        end
    endtask

    task automatic sb_pop(input int kind);
        int obs;
        obs = kind * 100000 + cur() * 10 + int'(bit_idx);
        if (exp_q.size() == 0) begin
            check_eq("ev_unexpected", obs, 0);
        end else begin
            check_eq("ev", obs, exp_q.pop_front());
        end
    endtask

    task automatic push_frame(input int b, input int d);
        exp_q.push_back(100000 + b * 10);
        for (int i = 0; i < CW; i++) begin
            exp_q.push_back(200000 + (b + d * (i + 1) - 1) * 10 + i);
        end
        exp_q.push_back(300000 + (b + d * CW - 1) * 10 + CW - 1);
    endtask

    task automatic wait_to(input int c);
        while (cur() < c) @(negedge clk);
    endtask

    task automatic new_base();
        @(negedge clk);
        base = cyc;
    endtask

    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (word_start) sb_pop(1);
            if (bit_tick)   sb_pop(2);
            if (word_end)   sb_pop(3);
        end
    end

    initial begin
        int acc;
        rst = 1'b1; start = 1'b0; stop = 1'b0; cfg_valid = 1'b0; cfg_div = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_busy", int'(busy), 0);
        check_eq("rst_cfg_ready", int'(cfg_ready), 1);
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst_bit_tick", int'(bit_tick), 0);
        check_eq("rst_word_start", int'(word_start), 0);
        check_eq("rst_word_end", int'(word_end), 0);
        check_eq("rst_bit_idx", int'(bit_idx), 0);
`ifdef CODEWORD_TIMER_LEVEL_EN
        check_eq("rst_div_level", int'(div_level), 0);
`endif
        mon_en = 1'b1;

        // Frame at div 7, stop mid-frame drains to the frame end
        new_base();
        start = 1'b1; push_frame(1, 7);
        @(negedge clk); start = 1'b0;
        wait_to(20); stop = 1'b1;
        @(negedge clk); stop = 1'b0;
        wait_to(49); check_eq("drain_busy49", int'(busy), 1);
        wait_to(50); check_eq("drain_busy50", int'(busy), 0);
        check_eq("drain_no_restart", int'(word_start), 0);
        wait_to(53); check_eq("t1_queue", exp_q.size(), 0);

        // Stop on the word_end cycle
        new_base();
        start = 1'b1; push_frame(1, 7);
        @(negedge clk); start = 1'b0;
        wait_to(49); stop = 1'b1;
        check_eq("we_at49", int'(word_end), 1);
        @(negedge clk); stop = 1'b0;
        check_eq("stop_we_busy50", int'(busy), 0);
        wait_to(53); check_eq("t2_queue", exp_q.size(), 0);

        // Ratio change mid-frame, second offer stalled until the boundary
        new_base();
        start = 1'b1;
        push_frame(1, 7); push_frame(50, 3); push_frame(71, 5);
        @(negedge clk); start = 1'b0;
        wait_to(10); cfg_valid = 1'b1; cfg_div = 8'd3;
        check_eq("cfg_ready10", int'(cfg_ready), 1);
        @(negedge clk); cfg_valid = 1'b0;
        check_eq("cfg_ready11", int'(cfg_ready), 0);
        wait_to(30); cfg_valid = 1'b1; cfg_div = 8'd5;
        acc = -1;
        for (int k = 0; k < 100; k++) begin
            if (cfg_ready) begin
                acc = cur();
                break;
            end
            @(negedge clk);
        end
        check_eq("stall_accept_cycle", acc, 50);
        @(negedge clk); cfg_valid = 1'b0;
        check_eq("cfg_ready51", int'(cfg_ready), 0);
        wait_to(71); check_eq("cfg_ready71", int'(cfg_ready), 1);
        wait_to(80); stop = 1'b1;
        @(negedge clk); stop = 1'b0;
        wait_to(105); check_eq("t3_busy105", int'(busy), 1);
        wait_to(106); check_eq("t3_busy106", int'(busy), 0);
        wait_to(110); check_eq("t3_queue", exp_q.size(), 0);

        // cfg_div 0 in IDLE -> 2; start+stop in IDLE runs; start in DRAIN resumes
        @(negedge clk);
        cfg_valid = 1'b1; cfg_div = 8'd0;
        check_eq("idle_cfg_ready", int'(cfg_ready), 1);
        @(negedge clk); cfg_valid = 1'b0;
        new_base();
        start = 1'b1; stop = 1'b1;
        push_frame(1, 2); push_frame(15, 2);
        @(negedge clk); start = 1'b0; stop = 1'b0;
        wait_to(5); stop = 1'b1;
        @(negedge clk); stop = 1'b0;
        wait_to(8); start = 1'b1;
        @(negedge clk); start = 1'b0;
        wait_to(20); stop = 1'b1;
        @(negedge clk); stop = 1'b0;
        wait_to(28); check_eq("t4_busy28", int'(busy), 1);
        wait_to(29); check_eq("t4_busy29", int'(busy), 0);
        wait_to(32); check_eq("t4_queue", exp_q.size(), 0);

        // Reset mid-frame with a pending ratio
        new_base();
        start = 1'b1; push_frame(1, 2);
        @(negedge clk); start = 1'b0;
        wait_to(3); cfg_valid = 1'b1; cfg_div = 8'd4;
        @(negedge clk); cfg_valid = 1'b0;
        check_eq("pend_cfg_ready", int'(cfg_ready), 0);
        wait_to(6);
        #2 rst = 1'b1;
        #1;
        check_eq("arst_busy", int'(busy), 0);
        check_eq("arst_bit_tick", int'(bit_tick), 0);
        check_eq("arst_word_start", int'(word_start), 0);
        check_eq("arst_bit_idx", int'(bit_idx), 0);
        check_eq("arst_cfg_ready", int'(cfg_ready), 1);
        exp_q.delete();
        @(negedge clk); rst = 1'b0;
        new_base();
        start = 1'b1; push_frame(1, 7);
        @(negedge clk); start = 1'b0; stop = 1'b1;
        @(negedge clk); stop = 1'b0;
`ifdef CODEWORD_TIMER_LEVEL_EN
        for (int k = 0; k < 14; k++) begin
            wait_to(1 + k);
            check_eq("div_level", int'(div_level), ((k % 7) < 4) ? 1 : 0);
        end
`endif
        wait_to(50); check_eq("t6_busy50", int'(busy), 0);
        wait_to(53); check_eq("t6_queue", exp_q.size(), 0);

        mon_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
